bcd_display_seq: RTL and testbench
==================================

Name: bcd_display_seq

Overview:
- Parametrised successor to the fixed 6-digit BCD-to-7-segment display block.
- Accepts an unsigned binary value through a valid/ready handshake and converts it to N_DIGITS BCD digits with a sequential double-dabble engine, one bit per clock.
- Drives N_DIGITS active-low 7-segment outputs, with overflow indication and optional leading-zero blanking.
- Sits between measurement/status logic (e.g. SSVEP frequency or sample counters) and the board HEX displays.

Parameters:
- N_DIGITS, 6: number of displayed digits; legal range 1..8.
- DATA_W, 20: width of the binary input; legal range 1..32.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  unsigned binary value to display.
- in_ready  output  1  block idle; a value is accepted on a rising edge with in_valid && in_ready.
- done  output  1  one-cycle pulse; outputs were updated on the preceding edge.
- overflow  output  1  last committed value was >= 10^N_DIGITS.
- bcd_out  output  4*N_DIGITS  committed BCD digits; digit 0 (units) is in bits [3:0].
- hex_out  output  7*N_DIGITS  committed segments.
  - Digit k occupies bits [7k+6:7k].
  - Within a digit, bit order is a..g = bit 0..6.
  - Segments are active-low.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - state IDLE, in_ready=1, done=0, overflow=0.
  - bcd_out=0.
  - every hex_out digit = SEG_BLANK (7'b1111111).
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - in_ready=1.
  - On accept: load in_data into the binary shift register, clear the BCD accumulator, set bit counter=DATA_W, latch ovf_pend = (in_data >= 10^N_DIGITS), go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: add 3 to every accumulator digit >= 5, then shift {bcd, bin} left by one in the same cycle, then decrement the counter.
  - After the DATA_W-th shift, go to COMMIT.
- COMMIT:
  - On the edge leaving COMMIT, register bcd_out, overflow=ovf_pend, and hex_out; go to IDLE.
  - done=1 for exactly the following cycle; in_ready=1 again in that same cycle.
- Latency: outputs update DATA_W+1 edges after the accept edge; done is asserted in the cycle after that update. Throughput is one value per DATA_W+2 cycles.
- Accumulator width:
  - The accumulator is 4*N_DIGITS bits; carries out of the top digit are discarded.
  - On overflow, bcd_out therefore holds the value mod 10^N_DIGITS.
  - The 10^N_DIGITS constant is computed at elaboration with a 64-bit width.
- Segment decode:
  - Digits 0-9 use standard patterns.
  - Any code >9 (cannot occur) decodes to SEG_BLANK.
  - When overflow is set, every hex_out digit = SEG_DASH (7'b0111111, segment g lit).
- in_valid while in_ready=0: ignored, not queued. The producer must hold in_valid until accepted.
- Simultaneous events: done and a new accept in the same cycle are legal; the new conversion starts with no lost cycle.
- Outputs hold their committed values between updates, including during SHIFT (no flicker).
- reset_n asserted mid-conversion: conversion aborted immediately; all outputs take their reset values.
- DATA_W small enough that 10^N_DIGITS > 2^DATA_W-1: overflow can never assert; the compare is optimised out.

Optional Feature:
- Macro: BCD_DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Every digit above the most significant non-zero digit shows SEG_BLANK.
  - Digit 0 always displays, so a value of 0 shows a single "0".
  - bcd_out is unaffected.
  - Overflow dashes take priority over blanking.
- Undefined: every digit always displays its value, zeros included.

Decomposition:
- Package bcd_display_pkg:
  - SEG_BLANK and SEG_DASH constants.
  - Function seg7_of(bcd[3:0]) returning the active-low pattern.
  - Function pow10(n) returning a 64-bit constant.
  - State enum typedef {IDLE, SHIFT, COMMIT}.
- Sub-module bcd_dabble_step: purely combinational one-iteration step (add-3 on each digit plus 1-bit shift), parametrised by N_DIGITS and DATA_W. The top-level FSM registers its output each SHIFT cycle.

Test Plan (N_DIGITS=6, DATA_W=20, macro undefined unless stated):
- Reset, then in_data=123456 accepted at edge t: hex_out/bcd_out unchanged until edge t+21; then bcd_out=24'h123456, segments show 1-2-3-4-5-6; done high one cycle; overflow=0.
- in_data=999999 -> bcd_out=24'h999999, overflow=0; in_data=1000000 -> overflow=1, all digits 7'b0111111, bcd_out=24'h000000; in_data=1048575 -> overflow=1, bcd_out=24'h048575.
- BCD_DISPLAY_LZ_BLANK_EN defined: in_data=0 -> digit0 shows "0", digits1-5 = SEG_BLANK; in_data=407 -> digits3-5 blank, digit1 shows "0".
- in_valid held during SHIFT with changing in_data -> ignored, in_ready=0; the second value is accepted only in the done cycle and commits 21 edges later.
- Assert reset_n at the 10th SHIFT cycle -> all hex_out digits = 7'b1111111, bcd_out=0, done never pulses; the next conversion of 42 completes correctly.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared constants, types and helpers for the BCD display converter.
// The optional leading-zero blanking is selected by BCD_DISPLAY_LZ_BLANK_EN in bcd_display_seq.
package bcd_display_pkg;

  // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  // Active-low 7-segment pattern for one BCD digit; illegal codes stay dark.
  function automatic logic [6:0] seg7_of(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // 10^n evaluated at elaboration; 64 bits covers every legal digit count.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_display_seq_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift
// {bcd, bin} left by one bit. Carries out of the top digit are dropped,
// which leaves the accumulator holding the value modulo 10^N_DIGITS.
module bcd_dabble_step #(
  parameter int N_DIGITS = 6,
  parameter int DATA_W   = 20
) (
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [DATA_W-1:0]     bin_in,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic [DATA_W-1:0]     bin_out
);

  localparam int BCD_W = 4 * N_DIGITS;

  logic [BCD_W-1:0]        adj;
  logic [BCD_W+DATA_W-1:0] shifted;

  // Per-digit add-3 correction ahead of the shift.
  always_comb begin
    adj = bcd_in;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (bcd_in[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = bcd_in[4*k +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {adj, bin_in} << 1;
  assign bcd_out = shifted[BCD_W+DATA_W-1:DATA_W];
  assign bin_out = shifted[DATA_W-1:0];

endmodule

// File: rtl/bcd_display_seq.sv
// Sequential binary-to-BCD converter driving N_DIGITS active-low 7-segment
// digits. One input bit is consumed per clock; committed outputs hold
// steady while the next conversion runs.
// Optional macro BCD_DISPLAY_LZ_BLANK_EN: blank digits above the most
// significant non-zero digit (digit 0 always shown, dashes take priority).
module bcd_display_seq
  import bcd_display_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int DATA_W   = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  done,
  output logic                  overflow,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic [7*N_DIGITS-1:0] hex_out
);

  localparam int              BCD_W = 4 * N_DIGITS;
  localparam int              HEX_W = 7 * N_DIGITS;
  localparam int              CNT_W = $clog2(DATA_W + 1);
  localparam logic [63:0]     LIMIT = pow10(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  bin_q, bin_d, bin_step;
  logic [BCD_W-1:0]   acc_q, acc_d, acc_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [HEX_W-1:0]   hex_q, hex_d, hex_commit;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               in_ovf;
`ifdef BCD_DISPLAY_LZ_BLANK_EN
  logic               lead_zero;
`endif

  // The compare folds away when DATA_W can never reach 10^N_DIGITS.
  assign in_ovf = ({{(64-DATA_W){1'b0}}, in_data} >= LIMIT);

  bcd_dabble_step #(
    .N_DIGITS (N_DIGITS),
    .DATA_W   (DATA_W)
  ) u_step (
    .bcd_in  (acc_q),
    .bin_in  (bin_q),
    .bcd_out (acc_step),
    .bin_out (bin_step)
  );

  // Segment image of the finished accumulator, ready to commit.
  always_comb begin
    hex_commit = '0;
`ifdef BCD_DISPLAY_LZ_BLANK_EN
    lead_zero = 1'b1;
`endif
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      hex_commit[7*k +: 7] = seg7_of(acc_q[4*k +: 4]);
`ifdef BCD_DISPLAY_LZ_BLANK_EN
      if ((acc_q[4*k +: 4] != 4'd0) || (k == 0)) begin
        lead_zero = 1'b0;
      end else if (lead_zero) begin
        hex_commit[7*k +: 7] = SEG_BLANK;
      end
`endif
      if (ovf_pend_q) begin
        hex_commit[7*k +: 7] = SEG_DASH;
      end
    end
  end

  // Next-state and datapath control for the IDLE/SHIFT/COMMIT sequence.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    hex_d      = hex_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d      = in_data;
          acc_d      = '0;
          cnt_d      = CNT_LOAD;
          ovf_pend_d = in_ovf;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = bin_step;
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        bcd_d   = acc_q;
        ovf_d   = ovf_pend_q;
        hex_d   = hex_commit;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any conversion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      hex_q      <= {N_DIGITS{SEG_BLANK}};
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      hex_q      <= hex_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd_out  = bcd_q;
  assign hex_out  = hex_q;

endmodule

// File: tb/tb_bcd_display_seq.sv
// Scoreboard bench for bcd_display_seq (N_DIGITS=6, DATA_W=20).
// Honours BCD_DISPLAY_LZ_BLANK_EN in its reference model.
module tb_bcd_display_seq;

  localparam int ND  = 6;
  localparam int DW  = 20;
  localparam int LAT = 21;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready, done, overflow;
  logic [4*ND-1:0] bcd_out;
  logic [7*ND-1:0] hex_out;

  typedef struct {
    logic [4*ND-1:0] bcd;
    logic [7*ND-1:0] hex;
    logic            ovf;
    int              due;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       held;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [6:0] seg_tab [10];

  bcd_display_seq #(.N_DIGITS(ND), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .done     (done),
    .overflow (overflow),
    .bcd_out  (bcd_out),
    .hex_out  (hex_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint p10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Expected display for a value: decimal digits by division, segments by lookup.
  function automatic exp_t model(input longint v, input int due);
    exp_t   e;
    longint m;
    bit     ov;
    int     d;
    m = v % p10(ND);
    ov = (v >= p10(ND));
    e.bcd = '0;
    e.hex = '0;
    e.ovf = ov;
    e.due = due;
    for (int k = 0; k < ND; k++) begin
      d = int'((m / p10(k)) % 10);
      e.bcd[4*k +: 4] = d[3:0];
      if (ov) e.hex[7*k +: 7] = 7'b0111111;
`ifdef BCD_DISPLAY_LZ_BLANK_EN
      else if (k > 0 && m < p10(k)) e.hex[7*k +: 7] = 7'b1111111;
`endif
      else e.hex[7*k +: 7] = seg_tab[d];
    end
    return e;
  endfunction

  function automatic exp_t reset_view();
    exp_t e;
    e.bcd = '0;
    e.hex = {ND{7'b1111111}};
    e.ovf = 1'b0;
    e.due = 0;
    return e;
  endfunction

  // Monitor: every cycle compare done against the schedule and outputs against the last commit.
  initial begin
    bit exp_done;
    held = reset_view();
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        void'(sb_q.pop_front());
      end
      exp_done = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      chk("done", done, exp_done);
      if (exp_done) held = sb_q.pop_front();
      chk("bcd_out", bcd_out, held.bcd);
      chk("hex_out", hex_out, held.hex);
      chk("overflow", overflow, held.ovf);
    end
  end

  task automatic wait_ready(output bit ok);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    ok = in_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual=in_ready low required=in_ready high");
    end
  endtask

  // Present one value, hold it until accepted, then log the expected commit.
  task automatic send(input logic [DW-1:0] v);
    bit ok;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    wait_ready(ok);
    if (ok) begin
      @(negedge clk);
      sb_q.push_back(model(longint'(v), cyc + LAT));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] v;
    int            g;
    seg_tab[0] = ~7'h3F; seg_tab[1] = ~7'h06; seg_tab[2] = ~7'h5B; seg_tab[3] = ~7'h4F;
    seg_tab[4] = ~7'h66; seg_tab[5] = ~7'h6D; seg_tab[6] = ~7'h7D; seg_tab[7] = ~7'h07;
    seg_tab[8] = ~7'h7F; seg_tab[9] = ~7'h6F;

    repeat (3) @(negedge clk);
    chk("in_ready_reset", in_ready, 1'b1);
    #2 reset_n = 1'b1;

    // Directed values including the overflow boundary and blanking cases.
    send(20'd123456);
    send(20'd999999);
    send(20'd1000000);
    send(20'd1048575);
    send(20'd0);
    send(20'd407);

    // Held in_valid with churning data while busy; accepted only in the done cycle.
    send(20'd31415);
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      in_data = DW'($urandom_range(0, 1048575));
      @(negedge clk);
      g++;
    end
    chk("busy_cycles", g, LAT);
    chk("done_with_ready", done, 1'b1);
    in_data = 20'd271828;
    @(negedge clk);
    sb_q.push_back(model(longint'(20'd271828), cyc + LAT));
    in_valid = 1'b0;

    // Reset in the 10th shift cycle aborts the conversion.
    send(20'd777777);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    sb_q.delete();
    held = reset_view();
    @(negedge clk);
    chk("in_ready_abort", in_ready, 1'b1);
    #2 reset_n = 1'b1;
    repeat (30) @(negedge clk);
    send(20'd42);

    // Randomised values across ranges.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       v = DW'($urandom_range(0, 1048575));
        1:       v = DW'($urandom_range(0, 999));
        2:       v = DW'($urandom_range(999990, 1000010));
        default: v = DW'($urandom_range(1000000, 1048575));
      endcase
      send(v);
    end

    g = 0;
    while (sb_q.size() > 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual=%0d pending required=0 pending", sb_q.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
